// File: rtl/flag_frame_tx_if.sv
// Byte-stream handshake and serial line bundle for the flag-delimited frame transmitter.
// The master side is the upstream framing logic (and whoever observes the line).
// The slave side is the transmitter itself.
interface flag_frame_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       frame_done;

  modport master (
    output data_in, data_valid, data_last,
    input  data_ready, out, out_valid, busy, frame_done
  );

  modport slave (
    input  data_in, data_valid, data_last,
    output data_ready, out, out_valid, busy, frame_done
  );
endinterface

// File: rtl/flag_frame_tx.sv
// Serial frame transmitter.
// Each frame is wrapped between two 0111_1110 flags, and a 0 is stuffed after
// every run of five payload 1s so the flag pattern never appears inside a frame.
// The block is a Moore machine: every output is decoded from registered state.
// The bit counter normally advances when a bit leaves the DATA state. When that
// bit is stuffed, the counter holds through the stuff cycle instead. This lets a
// STUFF cycle with cnt_r == 7 be recognised as the stuff that follows bit 7.
module flag_frame_tx (
  input  logic               clk,
  input  logic               rst,
  flag_frame_tx_if.slave     bus
);

  localparam logic [7:0] FLAG      = 8'b0111_1110;
  localparam logic [2:0] RUN_LIMIT = 3'd5;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FLAG_OPEN  = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_STUFF      = 3'd3;
  localparam logic [2:0] S_FLAG_CLOSE = 3'd4;

  logic [2:0] state_r;
  logic [2:0] cnt_r;
  logic [2:0] ones_r;
  logic [7:0] shreg_r;
  logic       last_r;

  logic       out_s;
  logic       out_valid_s;
  logic       stuff_s;
  logic       load_pt_s;
  logic       ready_s;
  logic       take_s;
  logic       done_s;

  // Decode line bit, stuff request, load point and frame end from registered state.
  always_comb begin
    out_s       = 1'b1;
    out_valid_s = 1'b0;
    stuff_s     = 1'b0;
    load_pt_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        out_s       = 1'b1;
        out_valid_s = 1'b0;
      end
      S_FLAG_OPEN: begin
        out_s       = FLAG[3'd7 - cnt_r];
        out_valid_s = 1'b1;
        load_pt_s   = (cnt_r == 3'd7);
      end
      S_DATA: begin
        out_s       = shreg_r[7];
        out_valid_s = 1'b1;
        stuff_s     = shreg_r[7] && (ones_r == (RUN_LIMIT - 3'd1));
        load_pt_s   = (cnt_r == 3'd7) && !stuff_s;
      end
      S_STUFF: begin
        out_s       = 1'b0;
        out_valid_s = 1'b1;
        load_pt_s   = (cnt_r == 3'd7);
      end
      S_FLAG_CLOSE: begin
        out_s       = FLAG[3'd7 - cnt_r];
        out_valid_s = 1'b1;
        done_s      = (cnt_r == 3'd7);
      end
      default: begin
        out_s       = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
    ready_s = load_pt_s && !last_r;
    take_s  = ready_s && bus.data_valid;
  end

  // Advance the FSM: frame start, bit shifting, run counting, stuffing and byte handover.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      ones_r  <= 3'd0;
      shreg_r <= 8'd0;
      last_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.data_valid) begin
            state_r <= S_FLAG_OPEN;
            cnt_r   <= 3'd0;
            ones_r  <= 3'd0;
            last_r  <= 1'b0;
          end else begin
            cnt_r   <= 3'd0;
            ones_r  <= 3'd0;
          end
        end
        S_FLAG_OPEN: begin
          ones_r <= 3'd0;
          if (load_pt_s) begin
            cnt_r <= 3'd0;
            if (take_s) begin
              shreg_r <= bus.data_in;
              last_r  <= bus.data_last;
              state_r <= S_DATA;
            end else begin
              state_r <= S_FLAG_CLOSE;
            end
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        S_DATA: begin
          shreg_r <= {shreg_r[6:0], 1'b0};
          if (shreg_r[7]) begin
            ones_r <= ones_r + 3'd1;
          end else begin
            ones_r <= 3'd0;
          end
          if (stuff_s) begin
            state_r <= S_STUFF;
          end else if (load_pt_s) begin
            cnt_r <= 3'd0;
            if (take_s) begin
              shreg_r <= bus.data_in;
              last_r  <= bus.data_last;
              state_r <= S_DATA;
            end else begin
              ones_r  <= 3'd0;
              state_r <= S_FLAG_CLOSE;
            end
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        S_STUFF: begin
          ones_r <= 3'd0;
          if (load_pt_s) begin
            cnt_r <= 3'd0;
            if (take_s) begin
              shreg_r <= bus.data_in;
              last_r  <= bus.data_last;
              state_r <= S_DATA;
            end else begin
              state_r <= S_FLAG_CLOSE;
            end
          end else begin
            cnt_r   <= cnt_r + 3'd1;
            state_r <= S_DATA;
          end
        end
        S_FLAG_CLOSE: begin
          ones_r <= 3'd0;
          if (cnt_r == 3'd7) begin
            cnt_r   <= 3'd0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 3'd0;
          ones_r  <= 3'd0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out        = out_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.data_ready = ready_s;
  assign bus.busy       = (state_r != S_IDLE);
  assign bus.frame_done = done_s;

endmodule

// File: tb/tb_flag_frame_tx.sv
// Testbench for flag_frame_tx.
// Directed frames with hand-written expected line streams. The stimulus pushes
// the expected bits into a queue, and a monitor pops and compares them whenever
// out_valid is high.
module tb_flag_frame_tx;

  logic clk;
  logic rst;

  flag_frame_tx_if bus ();

  flag_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks;
  int   failures;
  int   ov_cnt;
  int   rdy_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chkn(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_bits(input string s);
    exp_t x;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "1" || s[i] == "0") begin
        x.b = (s[i] == "1");
        x.d = 1'b0;
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic push_close();
    exp_t x;
    push_bits("0111111");
    x.b = 1'b0;
    x.d = 1'b1;
    exp_q.push_back(x);
  endtask

  task automatic put(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    bus.data_in    = b;
    bus.data_last  = l;
    bus.data_valid = 1'b1;
    @(negedge clk);
    while (!bus.data_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chkn("handshake_wait", (n < 100) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    ov_cnt  = 0;
    rdy_cnt = 0;
  endtask

  task automatic end_test(input string name, input int exp_len, input int exp_rdy);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    chkn({name, "_idle_wait"}, (n < 300) ? 1 : 0, 1);
    chkn({name, "_len"}, ov_cnt, exp_len);
    chkn({name, "_ready_pulses"}, rdy_cnt, exp_rdy);
    chkn({name, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every frame bit against the scoreboard, and check the idle line.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.data_ready) rdy_cnt++;
        if (bus.out_valid) begin
          ov_cnt++;
          if (exp_q.size() == 0) begin
            chk1("extra_bit", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk1("out_bit", bus.out, e.b);
            chk1("frame_done", bus.frame_done, e.d);
          end
        end else begin
          chk1("idle_out", bus.out, 1'b1);
          chk1("idle_done", bus.frame_done, 1'b0);
          chk1("idle_ready", bus.data_ready, 1'b0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    ov_cnt   = 0;
    rdy_cnt  = 0;
    rst            = 1'b1;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_out", bus.out, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_ready", bus.data_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single zero byte.
    begin_test();
    push_bits("01111110 00000000"); push_close();
    put(8'h00, 1'b1);
    bus.data_valid = 1'b0;
    end_test("t_00", 24, 1);

    // All ones: stuff after the fifth bit.
    begin_test();
    push_bits("01111110 11111 0 111"); push_close();
    put(8'hFF, 1'b1);
    bus.data_valid = 1'b0;
    end_test("t_ff", 25, 1);

    // Run of ones carried across a byte boundary.
    begin_test();
    push_bits("01111110 00000111 11 0 000000"); push_close();
    put(8'h07, 1'b0);
    put(8'hC0, 1'b1);
    bus.data_valid = 1'b0;
    end_test("t_carry", 33, 2);

    // Stuff owed by bit 7; the next byte is handed over in the stuff cycle.
    begin_test();
    push_bits("01111110 00011111 0 10000000"); push_close();
    put(8'h1F, 1'b0);
    put(8'h80, 1'b1);
    bus.data_valid = 1'b0;
    end_test("t_stuff7", 33, 2);

    // Underrun: no last flag, upstream goes quiet after one byte.
    begin_test();
    push_bits("01111110 10100101"); push_close();
    put(8'hA5, 1'b0);
    bus.data_valid = 1'b0;
    end_test("t_underrun", 24, 2);

    // Reset during the third data bit.
    begin_test();
    push_bits("01111110 001");
    put(8'h3C, 1'b1);
    bus.data_valid = 1'b0;
    n = 0;
    while (ov_cnt < 11 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chkn("rst_mid_wait", (n < 100) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_mid_out", bus.out, 1'b1);
    chk1("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk1("rst_mid_busy", bus.busy, 1'b0);
    chkn("rst_mid_leftover", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;

    // A fresh frame after reset starts with a complete opening flag.
    begin_test();
    push_bits("01111110 00000000"); push_close();
    put(8'h00, 1'b1);
    bus.data_valid = 1'b0;
    end_test("t_after_rst", 24, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
